// File: rtl/spi_flash_responder_pkg.sv
// Opcode constants and FSM state encoding shared by the SPI flash responder.
// SPI_FLASH_RESPONDER_FAST_READ_EN adds the DUMMY state used by fast read (0x0B).
package spi_flash_pkg;

  localparam logic [7:0] OP_READ       = 8'h03;
  localparam logic [7:0] OP_FAST_READ  = 8'h0B;
  localparam logic [7:0] OP_RELEASE_PD = 8'hAB;
  localparam logic [7:0] OP_POWER_DOWN = 8'hB9;
  localparam logic [7:0] OP_RESET      = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMMAND = 3'd1,
    ST_ADDRESS = 3'd2,
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    ST_DUMMY   = 3'd3,
`endif
    ST_DATA    = 3'd4,
    ST_IGNORE  = 3'd5
  } state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// Byte-wide read port between the responder (master) and its backing memory (slave).
interface spi_flash_responder_if #(parameter int ADDRESS_WIDTH = 24);

  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_request;
  logic [7:0]               mem_readData;
  logic                     mem_readDataValid;

  modport master (output mem_address, output mem_request,
                  input  mem_readData, input mem_readDataValid);
  modport slave  (input  mem_address, input mem_request,
                  output mem_readData, output mem_readDataValid);

endinterface

// File: rtl/spi_flash_responder_edge_sync.sv
// Synchronises the asynchronous SPI pins into clk and derives one-cycle sck/csb edge pulses.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic csb,
  input  logic sck,
  input  logic mosi,
  output logic csb_sync,
  output logic mosi_sync,
  output logic sck_rise,
  output logic sck_fall,
  output logic csb_rise,
  output logic csb_fall
);

  logic [SYNC_STAGES-1:0] csb_pipe_r;
  logic [SYNC_STAGES-1:0] sck_pipe_r;
  logic [SYNC_STAGES-1:0] mosi_pipe_r;
  logic                   csb_prev_r;
  logic                   sck_prev_r;

  // synchroniser chains plus one history flop for edge detection; mosi shares the depth so it lines up with sck
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_pipe_r  <= {SYNC_STAGES{1'b1}};
      sck_pipe_r  <= {SYNC_STAGES{1'b0}};
      mosi_pipe_r <= {SYNC_STAGES{1'b0}};
      csb_prev_r  <= 1'b1;
      sck_prev_r  <= 1'b0;
    end else begin
      csb_pipe_r  <= {csb_pipe_r[SYNC_STAGES-2:0], csb};
      sck_pipe_r  <= {sck_pipe_r[SYNC_STAGES-2:0], sck};
      mosi_pipe_r <= {mosi_pipe_r[SYNC_STAGES-2:0], mosi};
      csb_prev_r  <= csb_pipe_r[SYNC_STAGES-1];
      sck_prev_r  <= sck_pipe_r[SYNC_STAGES-1];
    end
  end

  assign csb_sync  = csb_pipe_r[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe_r[SYNC_STAGES-1];
  assign sck_rise  = sck_pipe_r[SYNC_STAGES-1] & ~sck_prev_r;
  assign sck_fall  = ~sck_pipe_r[SYNC_STAGES-1] & sck_prev_r;
  assign csb_rise  = csb_pipe_r[SYNC_STAGES-1] & ~csb_prev_r;
  assign csb_fall  = ~csb_pipe_r[SYNC_STAGES-1] & csb_prev_r;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash responder (0xFF, 0xAB, 0xB9, 0x03) with one-byte read prefetch.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to also accept 0x0B with 8 dummy clocks.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int ADDRESS_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_csb,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_we,
  spi_flash_responder_if.master mem,
  output logic                  powered_down,
  output logic                  underrun,
  output logic                  busy
);

  localparam logic [4:0] ADDR_LAST = 5'(ADDRESS_WIDTH - 1);

  logic csb_s, mosi_s, sck_rise_s, sck_fall_s, csb_rise_s, csb_fall_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .csb(spi_csb), .sck(spi_sck), .mosi(spi_mosi),
    .csb_sync(csb_s), .mosi_sync(mosi_s), .sck_rise(sck_rise_s), .sck_fall(sck_fall_s),
    .csb_rise(csb_rise_s), .csb_fall(csb_fall_s)
  );

  state_t                   state_r;
  logic [4:0]               bit_cnt_r;
  logic [2:0]               data_cnt_r;
  logic [7:0]               cmd_r, shift_r, prefetch_r;
  logic [ADDRESS_WIDTH-2:0] addr_r;
  logic [ADDRESS_WIDTH-1:0] fetch_addr_r, mem_address_r;
  logic boundary_r, miso_r, miso_we_r, mem_request_r, powered_down_r, underrun_r, busy_r;
  logic pending_r, discard_r, want_r, prefetch_valid_r;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  logic fast_r;
`endif

  logic [7:0]               cmd_next_s, load_byte_s;
  logic [ADDRESS_WIDTH-1:0] addr_next_s, req_addr_s;
  logic rdv_s, resp_keep_s, pending_now_s, avail_s, addr_end_s, load_s, want_s, issue_s;

  assign cmd_next_s    = {cmd_r[6:0], mosi_s};
  assign addr_next_s   = {addr_r, mosi_s};
  assign rdv_s         = mem.mem_readDataValid & pending_r;
  assign resp_keep_s   = rdv_s & ~discard_r;
  assign pending_now_s = pending_r & ~rdv_s;
  // a response landing in the very cycle of the load still counts as on time
  assign avail_s       = prefetch_valid_r | resp_keep_s;
  assign load_byte_s   = prefetch_valid_r ? prefetch_r : (resp_keep_s ? mem.mem_readData : 8'hFF);
  assign addr_end_s    = (state_r == ST_ADDRESS) & sck_rise_s & (bit_cnt_r == ADDR_LAST) & ~csb_rise_s;
  assign load_s        = (state_r == ST_DATA) & sck_fall_s & boundary_r & ~csb_rise_s;
  assign want_s        = want_r | addr_end_s | load_s;
  assign req_addr_s    = addr_end_s ? addr_next_s : fetch_addr_r;
  assign issue_s       = want_s & ~pending_now_s & ~csb_rise_s;

  // protocol FSM: command/address decode, miso shifting and power-down tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;  bit_cnt_r <= 5'd0;  data_cnt_r <= 3'd0;
      cmd_r <= 8'h00;  shift_r <= 8'h00;  addr_r <= '0;
      boundary_r <= 1'b0;  miso_r <= 1'b0;  miso_we_r <= 1'b0;
      powered_down_r <= 1'b1;  busy_r <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast_r <= 1'b0;
`endif
    end else begin
      busy_r <= ~csb_s;
      if (csb_rise_s) begin
        state_r <= ST_IDLE;  bit_cnt_r <= 5'd0;  data_cnt_r <= 3'd0;
        boundary_r <= 1'b0;  miso_r <= 1'b0;  miso_we_r <= 1'b0;
        if (state_r == ST_IGNORE && bit_cnt_r == 5'd8) begin
          if (cmd_r == OP_RELEASE_PD) powered_down_r <= 1'b0;
          else if (cmd_r == OP_POWER_DOWN) powered_down_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (csb_fall_s) begin
              state_r   <= ST_COMMAND;
              bit_cnt_r <= 5'd0;
            end
          end
          ST_COMMAND: begin
            if (sck_rise_s) begin
              cmd_r     <= cmd_next_s;
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd7) begin
                state_r <= ST_IGNORE;
                case (cmd_next_s)
                  OP_READ: begin
                    if (!powered_down_r) begin
                      state_r   <= ST_ADDRESS;
                      bit_cnt_r <= 5'd0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                      fast_r    <= 1'b0;
`endif
                    end
                  end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                  OP_FAST_READ: begin
                    if (!powered_down_r) begin
                      state_r   <= ST_ADDRESS;
                      bit_cnt_r <= 5'd0;
                      fast_r    <= 1'b1;
                    end
                  end
`else
                  OP_FAST_READ: state_r <= ST_IGNORE;
`endif
                  OP_RESET: state_r <= ST_IGNORE;
                  default:  state_r <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDRESS: begin
            if (sck_rise_s) begin
              addr_r    <= addr_next_s[ADDRESS_WIDTH-2:0];
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == ADDR_LAST) begin
                bit_cnt_r  <= 5'd0;
                data_cnt_r <= 3'd0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                if (fast_r) begin
                  state_r <= ST_DUMMY;
                end else begin
                  state_r    <= ST_DATA;
                  boundary_r <= 1'b1;
                end
`else
                state_r    <= ST_DATA;
                boundary_r <= 1'b1;
`endif
              end
            end
          end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          ST_DUMMY: begin
            if (sck_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd7) begin
                state_r    <= ST_DATA;
                boundary_r <= 1'b1;
              end
            end
          end
`endif
          ST_DATA: begin
            if (sck_fall_s) begin
              miso_we_r <= 1'b1;
              if (boundary_r) begin
                miso_r     <= load_byte_s[7];
                shift_r    <= {load_byte_s[6:0], 1'b0};
                boundary_r <= 1'b0;
              end else begin
                miso_r  <= shift_r[7];
                shift_r <= {shift_r[6:0], 1'b0};
              end
            end else if (sck_rise_s) begin
              data_cnt_r <= data_cnt_r + 3'd1;
              if (data_cnt_r == 3'd7) boundary_r <= 1'b1;
            end
          end
          ST_IGNORE: begin
            if (sck_rise_s && bit_cnt_r != 5'd31) bit_cnt_r <= bit_cnt_r + 5'd1;
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // memory port: single outstanding request, prefetch buffer, late-response discard
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_request_r <= 1'b0;  mem_address_r <= '0;  fetch_addr_r <= '0;
      pending_r <= 1'b0;  discard_r <= 1'b0;  want_r <= 1'b0;
      prefetch_r <= 8'h00;  prefetch_valid_r <= 1'b0;  underrun_r <= 1'b0;
    end else begin
      mem_request_r <= 1'b0;
      if (issue_s) begin
        mem_request_r <= 1'b1;
        mem_address_r <= req_addr_s;
        fetch_addr_r  <= req_addr_s + ADDRESS_WIDTH'(1);
        want_r        <= 1'b0;
      end else begin
        want_r <= want_s & ~csb_rise_s;
        if (addr_end_s) fetch_addr_r <= addr_next_s;
      end
      if (issue_s) pending_r <= 1'b1;
      else if (rdv_s) pending_r <= 1'b0;
      if (csb_rise_s || (load_s && !avail_s)) discard_r <= pending_now_s;
      else if (rdv_s) discard_r <= 1'b0;
      if (csb_rise_s || load_s) begin
        prefetch_valid_r <= 1'b0;
      end else if (resp_keep_s) begin
        prefetch_r       <= mem.mem_readData;
        prefetch_valid_r <= 1'b1;
      end
      if (load_s && !avail_s) underrun_r <= 1'b1;
    end
  end

  assign spi_miso        = miso_r;
  assign spi_miso_we     = miso_we_r;
  assign mem.mem_address = mem_address_r;
  assign mem.mem_request = mem_request_r;
  assign powered_down    = powered_down_r;
  assign underrun        = underrun_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised bench for spi_flash_responder against a transaction-level flash model.
module tb_spi_flash_responder;

  localparam int H = 4;  // sck half period in clk cycles
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, spi_csb, spi_sck, spi_mosi;
  logic spi_miso, spi_miso_we, powered_down, underrun, busy;

  spi_flash_responder_if mem_if ();

  spi_flash_responder #(.SYNC_STAGES(2), .ADDRESS_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_we(spi_miso_we), .mem(mem_if),
    .powered_down(powered_down), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000010: mem_byte = 8'hDE;
      24'h000011: mem_byte = 8'hAD;
      24'h000012: mem_byte = 8'hBE;
      24'h000013: mem_byte = 8'hEF;
      default:    mem_byte = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  int          lat = 1;
  logic [23:0] req_q[$];
  logic [7:0]  rx_q[$];
  logic        we_seen;

  // memory: answers each request after 'lat' cycles and logs its address
  initial begin : mem_model
    logic [23:0] a;
    mem_if.mem_readDataValid = 1'b0;
    mem_if.mem_readData      = 8'h00;
    forever begin
      @(negedge clk);
      mem_if.mem_readDataValid = 1'b0;
      if (mem_if.mem_request === 1'b1) begin
        a = mem_if.mem_address;
        req_q.push_back(a);
        repeat (lat) @(negedge clk);
        mem_if.mem_readData      = mem_byte(a);
        mem_if.mem_readDataValid = 1'b1;
      end
    end
  end

  always @(negedge clk) if (spi_miso_we === 1'b1) we_seen = 1'b1;

  task automatic spi_bit(input logic b, output logic r);
    spi_sck  = 1'b0;
    spi_mosi = b;
    repeat (H) @(negedge clk);
    r       = spi_miso;
    spi_sck = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // csb rises together with the final sck fall, so no extra byte boundary is seen
  task automatic spi_xfer(input logic [7:0] op, input int abits, input logic [23:0] addr,
                          input int dummy, input int nbytes);
    logic       r;
    logic [7:0] byte_v;
    rx_q.delete();
    req_q.delete();
    we_seen = 1'b0;
    byte_v  = 8'h00;
    @(negedge clk);
    spi_csb = 1'b0;
    repeat (H) @(negedge clk);
    check_eq("busy_open", busy, 1);
    for (int i = 7; i >= 0; i--) spi_bit(op[i], r);
    for (int i = 0; i < abits; i++) spi_bit(addr[23-i], r);
    for (int i = 0; i < dummy; i++) spi_bit(1'b0, r);
    for (int j = 0; j < nbytes; j++) begin
      for (int i = 0; i < 8; i++) begin
        spi_bit(1'b0, r);
        byte_v = {byte_v[6:0], r};
      end
      rx_q.push_back(byte_v);
    end
    spi_csb = 1'b1;
    spi_sck = 1'b0;
    repeat (3 * H) @(negedge clk);
  endtask

  logic model_pd;
  logic model_underrun;

  task automatic run_case(input string tag, input logic [7:0] op, input int abits,
                          input logic [23:0] addr, input int dummy, input int nbytes,
                          input int latency);
    bit          is_read;
    int          n_exp;
    logic [23:0] a;
    logic [7:0]  exp_b;
    lat = latency;
    spi_xfer(op, abits, addr, dummy, nbytes);
    is_read = (abits == 24) && !model_pd && nbytes > 0 &&
              ((op == 8'h03 && dummy == 0) || (FAST && op == 8'h0B && dummy == 8));
    n_exp = is_read ? nbytes + 1 : 0;
    check_eq($sformatf("%s_nreq", tag), req_q.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      a = addr + 24'(i);
      if (i < req_q.size()) check_eq($sformatf("%s_req%0d", tag, i), req_q[i], a);
    end
    if (is_read) begin
      for (int i = 0; i < nbytes; i++) begin
        a     = addr + 24'(i);
        exp_b = mem_byte(a);
        if (i == 0 && op == 8'h03 && latency > H - 1) begin
          exp_b          = 8'hFF;
          model_underrun = 1'b1;
        end
        check_eq($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_b);
      end
    end
    check_eq($sformatf("%s_we", tag), we_seen, is_read);
    if (abits == 0 && dummy == 0 && nbytes == 0) begin
      if (op == 8'hAB) model_pd = 1'b0;
      else if (op == 8'hB9) model_pd = 1'b1;
    end
    check_eq($sformatf("%s_pd", tag), powered_down, model_pd);
    check_eq($sformatf("%s_underrun", tag), underrun, model_underrun);
    check_eq($sformatf("%s_busy", tag), busy, 0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [23:0] addr;
    int          kind;
    rst = 1'b1;  spi_csb = 1'b1;  spi_sck = 1'b0;  spi_mosi = 1'b0;
    model_pd = 1'b1;  model_underrun = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_miso", spi_miso, 0);
    check_eq("rst_we", spi_miso_we, 0);
    check_eq("rst_req", mem_if.mem_request, 0);
    check_eq("rst_addr", mem_if.mem_address, 0);
    check_eq("rst_pd", powered_down, 1);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_case("pd_read",  8'h03, 24, 24'h000000, 0, 1, 1);
    run_case("release",  8'hAB, 0,  24'h0,      0, 0, 1);
    run_case("deadbeef", 8'h03, 24, 24'h000010, 0, 4, 1);
    run_case("wrap",     8'h03, 24, 24'hFFFFFE, 0, 3, 3);
    run_case("partial",  8'h03, 12, 24'h123456, 0, 0, 1);
    run_case("pdown",    8'hB9, 0,  24'h0,      0, 0, 1);
    run_case("release2", 8'hAB, 0,  24'h0,      0, 0, 1);
    run_case("pd_long",  8'hB9, 4,  24'hF00000, 0, 0, 1);
    run_case("fast",     8'h0B, 24, 24'h000020, 8, 2, 2);
    run_case("modereset",8'hFF, 0,  24'h0,      0, 0, 1);

    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 5);
      addr = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 2)) : 24'($urandom);
      case (kind)
        0: run_case($sformatf("rnd%0d_read", n), 8'h03, 24, addr, 0, $urandom_range(1, 3), $urandom_range(0, 3));
        1: run_case($sformatf("rnd%0d_ab", n), 8'hAB, 0, 24'h0, 0, 0, 1);
        2: run_case($sformatf("rnd%0d_b9", n), 8'hB9, $urandom_range(0, 1) * 3, 24'h0, 0, 0, 1);
        3: run_case($sformatf("rnd%0d_fast", n), 8'h0B, 24, addr, 8, $urandom_range(1, 2), $urandom_range(0, 3));
        4: begin
          op = 8'($urandom_range(0, 255));
          if (op == 8'h03 || op == 8'h0B) op = 8'h5C;
          run_case($sformatf("rnd%0d_op%02h", n, op), op, $urandom_range(0, 8), addr, 0, 0, 1);
        end
        default: run_case($sformatf("rnd%0d_ff", n), 8'hFF, 0, 24'h0, 0, 0, 1);
      endcase
    end

    run_case("ensure_up", 8'hAB, 0, 24'h0, 0, 0, 1);
    run_case("late",      8'h03, 24, 24'h000010, 0, 2, 5);
    run_case("after_late",8'h03, 24, 24'h000040, 0, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
